// File: rtl/ifetch_pkg.sv
// Shared types and default geometry for the instruction-fetch line buffer.
// Optional perf counters are enabled with IFETCH_PERF_CNT_EN.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT,
    RESP
  } state_t;

  localparam int WORD_BYTES     = 4;
  localparam int ADDR_W_DEF     = 32;
  localparam int LINE_BYTES_DEF = 16;
  localparam int NUM_LINES_DEF  = 4;

  localparam int OFFSET_W = $clog2(LINE_BYTES_DEF);
  localparam int INDEX_W  = $clog2(NUM_LINES_DEF);
  localparam int TAG_W    = ADDR_W_DEF - OFFSET_W - INDEX_W;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } fetch_resp_t;

endpackage

// File: rtl/ifetch_line_store.sv
// Direct-mapped tag/valid/data arrays for the fetch line buffer.
// One combinational read port, one fill port, synchronous invalidate-all.
module ifetch_line_store #(
  parameter int NUM_LINES = 4,
  parameter int IW        = 2,
  parameter int TAG_W     = 26,
  parameter int LINE_W    = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IW-1:0]     rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              inval_all
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  // invalidate wins over a same-cycle fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (inval_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

endmodule

// File: rtl/ifetch_line_buffer.sv
// Instruction-fetch controller: direct-mapped line buffer in front of imemory.
// Define IFETCH_PERF_CNT_EN to add perf_hits / perf_misses outputs.
module ifetch_line_buffer
  import ifetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int NUM_LINES  = NUM_LINES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req_valid,
  input  logic [ADDR_WIDTH-1:0]   cpu_req_addr,
  output logic                    cpu_req_ready,
  output logic                    cpu_resp_valid,
  output logic [31:0]             cpu_resp_data,
  input  logic                    flush,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0]             perf_hits,
  output logic [31:0]             perf_misses,
`endif
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic                    mem_start,
  input  logic                    mem_rdy,
  input  logic [8*LINE_BYTES-1:0] mem_data
);

  localparam int OFF_BITS = $clog2(LINE_BYTES);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int IW       = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int TAG_BITS = ADDR_WIDTH - OFF_BITS - IDX_BITS;
  localparam int WS       = OFF_BITS - $clog2(WORD_BYTES);
  localparam int LINE_W   = 8 * LINE_BYTES;

  function automatic logic [IW-1:0] idx_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    return IW'((a >> OFF_BITS) & ADDR_WIDTH'(NUM_LINES - 1));
  endfunction

  function automatic logic [TAG_BITS-1:0] tag_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    return TAG_BITS'(a >> (OFF_BITS + IDX_BITS));
  endfunction

  function automatic logic [WS-1:0] wsel_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    return a[OFF_BITS-1:2];
  endfunction

  function automatic logic [31:0] word_of(
    input logic [LINE_W-1:0] l,
    input logic [WS-1:0]     w
  );
    return l[32*w +: 32];
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WS-1:0]         wsel_q;
  logic                  killed_q;
  fetch_resp_t           pend_q;
  logic [31:0]           last_q;

  logic                  accept;
  logic                  hit;
  logic                  kill;
  logic                  fill;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [LINE_W-1:0]     rd_line;

  ifetch_line_store #(
    .NUM_LINES (NUM_LINES),
    .IW        (IW),
    .TAG_W     (TAG_BITS),
    .LINE_W    (LINE_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (reset),
    .rd_idx    (idx_of(cpu_req_addr)),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_en     (fill),
    .wr_idx    (idx_of(mem_addr_q)),
    .wr_tag    (tag_of(mem_addr_q)),
    .wr_line   (mem_data),
    .inval_all (flush)
  );

  assign cpu_req_ready = (state_q == IDLE) && !flush;
  assign accept        = cpu_req_valid && cpu_req_ready;
  assign hit           = rd_valid && (rd_tag == tag_of(cpu_req_addr));
  // a flush coinciding with mem_rdy kills the fill just like a registered kill
  assign kill          = killed_q || flush;
  assign fill          = (state_q == MISS_WAIT) && mem_rdy && !kill;

  assign mem_start      = (state_q == MISS_REQ);
  assign mem_address    = mem_addr_q;
  assign cpu_resp_valid = pend_q.valid && !flush;
  assign cpu_resp_data  = cpu_resp_valid ? pend_q.data : last_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept && !hit) state_d = MISS_REQ;
      MISS_REQ:  state_d = MISS_WAIT;
      MISS_WAIT: if (mem_rdy) state_d = kill ? IDLE : RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      wsel_q     <= '0;
      killed_q   <= 1'b0;
      pend_q     <= '0;
      last_q     <= '0;
    end else begin
      state_q      <= state_d;
      pend_q.valid <= 1'b0;
      if (accept) begin
        wsel_q <= wsel_of(cpu_req_addr);
        if (hit) begin
          pend_q.valid <= 1'b1;
          pend_q.data  <= word_of(rd_line, wsel_of(cpu_req_addr));
        end else begin
          mem_addr_q <= {cpu_req_addr[ADDR_WIDTH-1:OFF_BITS],
                         {OFF_BITS{1'b0}}};
        end
      end
      if (fill) begin
        pend_q.valid <= 1'b1;
        pend_q.data  <= word_of(mem_data, wsel_q);
      end
      if (cpu_resp_valid) last_q <= pend_q.data;
      if (state_d == IDLE) begin
        killed_q <= 1'b0;
      end else if (flush && (state_q == MISS_REQ
                          || state_q == MISS_WAIT)) begin
        killed_q <= 1'b1;
      end
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if (accept) begin
      if (hit) perf_hits <= perf_hits + 32'd1;
      else     perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Self-checking bench for ifetch_line_buffer: directed scenarios plus
// randomized traffic compared against a timeline model of the fetch buffer.
module tb_ifetch_line_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req_valid;
  logic [31:0]  cpu_req_addr;
  logic         cpu_req_ready;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_data;
  logic         flush;
  logic [31:0]  mem_address;
  logic         mem_start;
  logic         mem_rdy;
  logic [127:0] mem_data;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]  perf_hits;
  logic [31:0]  perf_misses;
`endif

  always #5 clk = ~clk;

  ifetch_line_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_data  (cpu_resp_data),
    .flush          (flush),
`ifdef IFETCH_PERF_CNT_EN
    .perf_hits      (perf_hits),
    .perf_misses    (perf_misses),
`endif
    .mem_address    (mem_address),
    .mem_start      (mem_start),
    .mem_rdy        (mem_rdy),
    .mem_data       (mem_data)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // memory contents: each word is derived from its own byte address
  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [15:0] w;
    w = a[15:0] & 16'hFFFC;
    return {w, ~w};
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] la);
    return {memword(la + 12), memword(la + 8), memword(la + 4), memword(la)};
  endfunction

  // reference model: which line address each index holds, plus the
  // timeline of the single outstanding miss and the next response
  bit          mvalid [4];
  logic [31:0] mline  [4];
  bit          miss_act;
  bit          miss_kill;
  int          miss_start;
  logic [31:0] miss_addr;
  logic [31:0] miss_word;
  int          due_cyc  = -1;
  logic [31:0] due_data;
  int          resp_cyc = -1;
  logic [31:0] last_data = '0;
  int          exp_hits = 0;
  int          exp_misses = 0;

  int          n = 0;
  int          rdy_at = -1;
  logic [127:0] rdy_line;
  int          dly_lo = 1;
  int          dly_hi = 5;
  bit          stray_en = 0;

  int          n_start = 0;
  int          n_resp = 0;
  logic [31:0] obs_start_addr;
  logic [31:0] obs_q[$];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mvalid[i] = 0;
    miss_act = 0;
    miss_kill = 0;
    due_cyc = -1;
    resp_cyc = -1;
    last_data = '0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic cycle(input bit v, input logic [31:0] a, input bit f);
    bit          exp_ready;
    bit          exp_start;
    bit          exp_rv;
    int          idx;
    logic [31:0] r0;
    logic [31:0] r1;
    cpu_req_valid = v;
    cpu_req_addr  = a;
    flush         = f;
    if (n == rdy_at) begin
      mem_rdy  = 1'b1;
      mem_data = rdy_line;
    end else if (stray_en && !miss_act && $urandom_range(0, 15) == 0) begin
      r0 = $urandom();
      r1 = $urandom();
      mem_rdy  = 1'b1;
      mem_data = {r0, r1, r1, r0};
    end else begin
      mem_rdy  = 1'b0;
    end
    #1;
    exp_ready = !miss_act && (resp_cyc != n) && !f;
    exp_start = miss_act && (n == miss_start);
    exp_rv    = (due_cyc == n) && !f;
    chk("req_ready", 32'(cpu_req_ready), 32'(exp_ready));
    chk("mem_start", 32'(mem_start), 32'(exp_start));
    if (miss_act && n >= miss_start)
      chk("mem_address", mem_address, miss_addr);
    chk("resp_valid", 32'(cpu_resp_valid), 32'(exp_rv));
    if (exp_rv) chk("resp_data", cpu_resp_data, due_data);
    else        chk("resp_hold", cpu_resp_data, last_data);
`ifdef IFETCH_PERF_CNT_EN
    chk("perf_hits", perf_hits, 32'(exp_hits));
    chk("perf_misses", perf_misses, 32'(exp_misses));
`endif
    if (mem_start) begin
      n_start++;
      obs_start_addr = mem_address;
      rdy_at   = n + $urandom_range(dly_lo, dly_hi);
      rdy_line = line_of(mem_address);
    end
    if (cpu_resp_valid) begin
      n_resp++;
      obs_q.push_back(cpu_resp_data);
    end
    if (exp_rv) last_data = due_data;
    if (v && exp_ready) begin
      idx = int'((a >> 4) & 32'd3);
      if (mvalid[idx] && mline[idx] == (a & ~32'hF)) begin
        due_cyc  = n + 1;
        due_data = memword(a);
        exp_hits++;
      end else begin
        miss_act   = 1;
        miss_kill  = 0;
        miss_start = n + 1;
        miss_addr  = a & ~32'hF;
        miss_word  = memword(a);
        exp_misses++;
      end
    end
    if (miss_act && n > miss_start && mem_rdy) begin
      if (!(miss_kill || f)) begin
        idx = int'((miss_addr >> 4) & 32'd3);
        mvalid[idx] = 1;
        mline[idx]  = miss_addr;
        due_cyc     = n + 1;
        due_data    = miss_word;
        resp_cyc    = n + 1;
      end
      miss_act = 0;
    end
    if (f) begin
      for (int i = 0; i < 4; i++) mvalid[i] = 0;
      if (miss_act) miss_kill = 1;
    end
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic wait_resp(input string nm);
    int r0;
    r0 = n_resp;
    for (int i = 0; i < 30 && n_resp == r0; i++) cycle(0, 32'h0, 0);
    chk(nm, 32'(n_resp > r0), 32'd1);
  endtask

  int s0;
  int r0;

  initial begin
    reset = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_addr = '0;
    flush = 1'b0;
    mem_rdy = 1'b0;
    mem_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    chk("rst resp_valid", 32'(cpu_resp_valid), 32'd0);
    chk("rst resp_data", cpu_resp_data, 32'd0);
    chk("rst mem_start", 32'(mem_start), 32'd0);
    chk("rst mem_address", mem_address, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // cold miss
    s0 = n_start;
    obs_q.delete();
    cycle(1, 32'h104, 0);
    wait_resp("cold resp timeout");
    chk("cold start addr", obs_start_addr, 32'h100);
    chk("cold starts", 32'(n_start - s0), 32'd1);
    chk("cold data", (obs_q.size() > 0) ? obs_q[0] : 32'hDEAD, 32'h0104FEFB);

    // hit streaming
    s0 = n_start;
    obs_q.delete();
    cycle(1, 32'h100, 0);
    cycle(1, 32'h108, 0);
    cycle(1, 32'h10C, 0);
    cycle(0, 32'h0, 0);
    chk("stream count", 32'(obs_q.size()), 32'd3);
    chk("stream w0", (obs_q.size() > 0) ? obs_q[0] : 32'hDEAD, 32'h0100FEFF);
    chk("stream w2", (obs_q.size() > 1) ? obs_q[1] : 32'hDEAD, 32'h0108FEF7);
    chk("stream w3", (obs_q.size() > 2) ? obs_q[2] : 32'hDEAD, 32'h010CFEF3);
    chk("stream no start", 32'(n_start - s0), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    chk("perf misses lit", perf_misses, 32'd1);
    chk("perf hits lit", perf_hits, 32'd3);
`endif

    // conflict eviction
    s0 = n_start;
    cycle(1, 32'h140, 0);
    wait_resp("evict resp timeout");
    chk("evict start addr", obs_start_addr, 32'h140);
    cycle(1, 32'h100, 0);
    wait_resp("refill resp timeout");
    chk("refill start addr", obs_start_addr, 32'h100);
    chk("evict starts", 32'(n_start - s0), 32'd2);

    // flush during the memory wait
    dly_lo = 3;
    dly_hi = 3;
    s0 = n_start;
    r0 = n_resp;
    cycle(1, 32'h200, 0);
    cycle(0, 32'h0, 0);
    cycle(0, 32'h0, 1);
    repeat (6) cycle(0, 32'h0, 0);
    chk("flush no resp", 32'(n_resp - r0), 32'd0);
    cycle(1, 32'h200, 0);
    wait_resp("post flush timeout");
    chk("flush starts", 32'(n_start - s0), 32'd2);

    // async reset while waiting on memory; the late mem_rdy must be ignored
    cycle(1, 32'h300, 0);
    cycle(0, 32'h0, 0);
    cpu_req_valid = 1'b0;
    flush = 1'b0;
    mem_rdy = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("arst resp_valid", 32'(cpu_resp_valid), 32'd0);
    chk("arst resp_data", cpu_resp_data, 32'd0);
    chk("arst mem_start", 32'(mem_start), 32'd0);
    chk("arst mem_address", mem_address, 32'd0);
    chk("arst ready", 32'(cpu_req_ready), 32'd1);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    n++;
    r0 = n_resp;
    repeat (4) cycle(0, 32'h0, 0);
    chk("stray rdy no resp", 32'(n_resp - r0), 32'd0);
    s0 = n_start;
    cycle(1, 32'h100, 0);
    wait_resp("post reset timeout");
    chk("post reset miss", 32'(n_start - s0), 32'd1);

    // randomized traffic
    dly_lo = 1;
    dly_hi = 5;
    stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 1) == 1,
            32'($urandom_range(0, 32'h3FF)),
            $urandom_range(0, 39) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
